// File: rtl/csi2_lane_byte_align_pkg.sv
// Shared types and helpers for the CSI-2 per-lane byte aligner.
package csi2_align_pkg;

    // Aligner control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // HS leader sync byte, LSB = first bit on the wire
    localparam logic [7:0] SYNC_PATTERN_DEF = 8'hB8;

    // Mask of the k window bits that sit below a sync candidate at offset k;
    // those bits must be HS-zero for the candidate to count.
    function automatic logic [15:0] offset_mask(input logic [2:0] k);
        return (16'd1 << k) - 16'd1;
    endfunction

endpackage

// File: rtl/csi2_lane_byte_align_if.sv
// Lane-side bus of the byte aligner: bit-aligner inputs and merger outputs.
interface csi2_lane_byte_align_if;

    logic       BIT_ALGN_DONE;
    logic       LP_IN;
    logic [7:0] DATA_IN;
    logic       DATA_VALID;
    logic [7:0] BYTE_OUT;
    logic       BYTE_VALID;
    logic       SYNC_FOUND;
    logic       SYNC_ERR;
    logic       LOCKED;
    logic [2:0] BYTE_OFFSET;

    // Upstream side: drives deserialised data, observes aligned bytes
    modport master (
        output BIT_ALGN_DONE, LP_IN, DATA_IN, DATA_VALID,
        input  BYTE_OUT, BYTE_VALID, SYNC_FOUND, SYNC_ERR, LOCKED, BYTE_OFFSET
    );

    // Aligner side
    modport slave (
        input  BIT_ALGN_DONE, LP_IN, DATA_IN, DATA_VALID,
        output BYTE_OUT, BYTE_VALID, SYNC_FOUND, SYNC_ERR, LOCKED, BYTE_OFFSET
    );

endinterface

// File: rtl/csi2_lane_byte_align_sync_detect.sv
// Combinational sync-byte search over a 16-bit window at bit offsets 0..7.
// The lowest matching offset wins.
module csi2_sync_detect
    import csi2_align_pkg::*;
(
    input  logic [15:0] win_i,
    input  logic [7:0]  pattern_i,
    output logic        match_o,
    output logic [2:0]  offset_o
);

    // Priority encode: scan from the top so the lowest hit is written last
    always_comb begin
        match_o  = 1'b0;
        offset_o = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if ((win_i[4'(k) +: 8] == pattern_i) &&
                ((win_i & offset_mask(3'(k))) == 16'd0)) begin
                match_o  = 1'b1;
                offset_o = 3'(k);
            end
        end
    end

endmodule

// File: rtl/csi2_lane_byte_align.sv
// Per-lane CSI-2 HS byte aligner. Hunts for the sync byte at any bit offset
// once bit alignment is done, then emits byte-aligned payload with one cycle
// of latency. Any LP entry or loss of bit alignment drops back to IDLE.
module csi2_lane_byte_align
    import csi2_align_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN  = SYNC_PATTERN_DEF,
    parameter int         TIMEOUT_WIDTH = 10
) (
    input  logic                   SCLK,
    input  logic                   RESET,
    csi2_lane_byte_align_if.slave  lane
);

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = '1;

    state_t                   state_q;
    logic [7:0]               prev_q;
    logic [7:0]               byte_q;
    logic                     byte_vld_q;
    logic                     found_q;
    logic                     err_q;
    logic                     locked_q;
    logic [2:0]               off_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_d;

    logic [15:0] win;
    logic        match;
    logic [2:0]  match_off;
    logic        exit_req;

    // Current byte on top of the previous one: a sync spanning two beats is
    // visible in a single window.
    assign win      = {lane.DATA_IN, prev_q};
    assign exit_req = lane.LP_IN | ~lane.BIT_ALGN_DONE;
    assign cnt_d    = cnt_q + 1'b1;

    csi2_sync_detect u_sync_detect (
        .win_i     (win),
        .pattern_i (SYNC_PATTERN),
        .match_o   (match),
        .offset_o  (match_off)
    );

    // Hunt/lock state machine; every output comes straight from a flop
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            prev_q     <= 8'h00;
            cnt_q      <= '0;
            byte_q     <= 8'h00;
            byte_vld_q <= 1'b0;
            found_q    <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
            off_q      <= 3'd0;
        end else begin
            byte_vld_q <= 1'b0;
            found_q    <= 1'b0;
            err_q      <= 1'b0;
            // The window history runs in every state so a hunt can start
            // on the very next beat.
            if (lane.DATA_VALID) begin
                prev_q <= lane.DATA_IN;
            end
            if (exit_req) begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= HUNT;
                        cnt_q   <= '0;
                    end
                    HUNT: begin
                        if (lane.DATA_VALID) begin
                            if (match) begin
                                // Sync byte is consumed, never forwarded
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                off_q    <= match_off;
                                found_q  <= 1'b1;
                                cnt_q    <= '0;
                            end else if (cnt_d == CNT_LAST) begin
                                err_q <= 1'b1;
                                cnt_q <= '0;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end
                    end
                    LOCKED: begin
                        // Payload may legitimately contain the sync value,
                        // so the offset stays fixed until the next exit.
                        if (lane.DATA_VALID) begin
                            byte_q     <= win[{1'b0, off_q} +: 8];
                            byte_vld_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lane.BYTE_OUT    = byte_q;
    assign lane.BYTE_VALID  = byte_vld_q;
    assign lane.SYNC_FOUND  = found_q;
    assign lane.SYNC_ERR    = err_q;
    assign lane.LOCKED      = locked_q;
    assign lane.BYTE_OFFSET = off_q;

endmodule

// File: tb/tb_csi2_lane_byte_align.sv
// Bench for the CSI-2 lane byte aligner: directed and randomized bit streams
// checked cycle by cycle against a behavioural model of the alignment rules.
module tb_csi2_lane_byte_align;

    localparam logic [7:0] SYNC = 8'hB8;
    localparam int         TW   = 4;
    localparam int         TMAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    csi2_lane_byte_align_if lane();

    csi2_lane_byte_align #(
        .SYNC_PATTERN  (SYNC),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .SCLK  (clk),
        .RESET (rst),
        .lane  (lane)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Packed view of every output: {BYTE_OUT, BYTE_VALID, SYNC_FOUND, SYNC_ERR, LOCKED, BYTE_OFFSET}
    logic [14:0] obs;
    logic [14:0] exp_v;
    assign obs = {lane.BYTE_OUT, lane.BYTE_VALID, lane.SYNC_FOUND,
                  lane.SYNC_ERR, lane.LOCKED, lane.BYTE_OFFSET};

    // Reference model state: 0 idle, 1 hunting, 2 locked
    int         mst, mcnt;
    logic [7:0] mprev, mbyte;
    logic [2:0] moff;
    logic       mvalid, mfound, merr;

    logic [7:0]  pay_q[$];
    logic [7:0]  strm_q[$];
    logic [7:0]  got_q[$];
    logic [14:0] obs_log[$];
    logic [14:0] exp_log[$];
    int          sidx;
    int          nfound;

    // Apply one clock of inputs, advance the model, log what the DUT shows
    task automatic step(input logic d, input logic l, input logic v, input logic [7:0] x);
        int w;
        int hit;
        lane.BIT_ALGN_DONE = d;
        lane.LP_IN         = l;
        lane.DATA_VALID    = v;
        lane.DATA_IN       = x;
        mvalid = 1'b0;
        mfound = 1'b0;
        merr   = 1'b0;
        if (rst) begin
            mst = 0; mcnt = 0; mprev = 8'h00; mbyte = 8'h00; moff = 3'd0;
        end else begin
            w = int'({x, mprev});
            if (l || !d) begin
                mst = 0; mcnt = 0;
            end else if (mst == 0) begin
                mst = 1; mcnt = 0;
            end else if (mst == 1 && v) begin
                hit = -1;
                for (int k = 0; k < 8; k++)
                    if (hit < 0 && ((w >> k) & 255) == int'(SYNC) && (w % (1 << k)) == 0)
                        hit = k;
                if (hit >= 0) begin
                    mst = 2; moff = 3'(hit); mfound = 1'b1; mcnt = 0;
                end else begin
                    mcnt++;
                    if (mcnt == TMAX) begin
                        merr = 1'b1; mcnt = 0;
                    end
                end
            end else if (mst == 2 && v) begin
                mbyte  = 8'((w >> moff) & 255);
                mvalid = 1'b1;
            end
            if (v) mprev = x;
        end
        exp_v = {mbyte, mvalid, mfound, merr, (mst == 2), moff};
        @(posedge clk);
        #1;
        obs_log.push_back(obs);
        exp_log.push_back(exp_v);
        if (lane.BYTE_VALID) got_q.push_back(lane.BYTE_OUT);
        if (lane.SYNC_FOUND) nfound++;
    endtask

    task automatic clear_logs();
        obs_log.delete();
        exp_log.delete();
        got_q.delete();
        nfound = 0;
    endtask

    // Leave the lane: one LP cycle to IDLE, one cycle to start hunting
    task automatic restart();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // Serialise one zero byte, k HS-zero bits, the sync byte and pay_q
    // LSB-first, pad to whole bytes plus one trailing zero byte.
    task automatic build_stream(input int k);
        bit         bits[$];
        logic [7:0] b;
        strm_q.delete();
        for (int i = 0; i < 8 + k; i++) bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(SYNC[i]);
        foreach (pay_q[p])
            for (int j = 0; j < 8; j++) bits.push_back(pay_q[p][j]);
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(1'b0);
        for (int n = 0; n < bits.size() / 8; n++) begin
            for (int j = 0; j < 8; j++) b[j] = bits[n * 8 + j];
            strm_q.push_back(b);
        end
        sidx = 0;
    endtask

    // Drive up to nbeats valid beats of strm_q, optionally with idle gaps
    task automatic play(input bit gaps, input int nbeats);
        int n = 0;
        while (sidx < strm_q.size() && n < nbeats) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                step(1'b1, 1'b0, 1'b0, 8'h00);
            end else begin
                step(1'b1, 1'b0, 1'b1, strm_q[sidx]);
                sidx++;
                n++;
            end
        end
    endtask

    task automatic random_payload(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        lane.BIT_ALGN_DONE = 1'b0;
        lane.LP_IN         = 1'b0;
        lane.DATA_VALID    = 1'b0;
        lane.DATA_IN       = 8'h00;
        mst = 0; mcnt = 0; mprev = 8'h00; mbyte = 8'h00; moff = 3'd0;
        clear_logs();
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_async: outputs %h, required %h", obs, 15'h0);
        end
        step(1'b1, 1'b0, 1'b1, SYNC);
        step(1'b1, 1'b0, 1'b1, 8'h11);
        rst = 1'b0;
        foreach (obs_log[i]) begin
            vectors++;
            if (obs_log[i] !== 15'h0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: outputs %h, required %h", i, obs_log[i], 15'h0);
            end
        end
    endtask

    task automatic test_offset0();
        clear_logs();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        strm_q = '{8'h00, 8'h00, 8'hB8, 8'h11, 8'h22, 8'h00};
        sidx = 0;
        play(1'b0, 100);
        foreach (obs_log[i]) begin
            vectors++;
            if (obs_log[i] !== exp_log[i]) begin
                miscompares++;
                $display("FAIL offset0 cycle %0d: outputs %h, model %h", i, obs_log[i], exp_log[i]);
            end
        end
        vectors++;
        if (got_q.size() < 2 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin
            miscompares++;
            $display("FAIL offset0_bytes: got %p, required 11 22", got_q);
        end
        vectors++;
        if (lane.BYTE_OFFSET !== 3'd0 || nfound != 1) begin
            miscompares++;
            $display("FAIL offset0_sync: offset %0d found %0d, required offset 0 found 1", lane.BYTE_OFFSET, nfound);
        end
    endtask

    task automatic test_offset3();
        clear_logs();
        restart();
        strm_q = '{8'h00, 8'hC0, 8'h2D, 8'hE5, 8'h01, 8'h00};
        sidx = 0;
        play(1'b0, 100);
        foreach (obs_log[i]) begin
            vectors++;
            if (obs_log[i] !== exp_log[i]) begin
                miscompares++;
                $display("FAIL offset3 cycle %0d: outputs %h, model %h", i, obs_log[i], exp_log[i]);
            end
        end
        vectors++;
        if (got_q.size() < 2 || got_q[0] !== 8'hA5 || got_q[1] !== 8'h3C) begin
            miscompares++;
            $display("FAIL offset3_bytes: got %p, required a5 3c", got_q);
        end
        vectors++;
        if (lane.BYTE_OFFSET !== 3'd3) begin
            miscompares++;
            $display("FAIL offset3_offset: offset %0d, required 3", lane.BYTE_OFFSET);
        end
    endtask

    task automatic test_payload_b8();
        logic [7:0] g;
        clear_logs();
        restart();
        pay_q = '{8'($urandom), 8'hB8, 8'($urandom), 8'($urandom), 8'hB8, 8'($urandom)};
        build_stream(5);
        play(1'b1, 100);
        foreach (obs_log[i]) begin
            vectors++;
            if (obs_log[i] !== exp_log[i]) begin
                miscompares++;
                $display("FAIL payload_b8 cycle %0d: outputs %h, model %h", i, obs_log[i], exp_log[i]);
            end
        end
        foreach (pay_q[j]) begin
            g = (j < got_q.size()) ? got_q[j] : 8'hxx;
            vectors++;
            if (g !== pay_q[j]) begin
                miscompares++;
                $display("FAIL payload_b8 byte %0d: got %h, required %h", j, g, pay_q[j]);
            end
        end
        vectors++;
        if (lane.BYTE_OFFSET !== 3'd5 || nfound != 1 || lane.LOCKED !== 1'b1) begin
            miscompares++;
            $display("FAIL payload_b8_lock: offset %0d found %0d locked %b, required 5 1 1",
                     lane.BYTE_OFFSET, nfound, lane.LOCKED);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        restart();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h55);
            vectors++;
            if (lane.SYNC_ERR !== ((i == 14) || (i == 29)) || lane.LOCKED !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout beat %0d: sync_err %b locked %b, required %b 0",
                         i + 1, lane.SYNC_ERR, lane.LOCKED, (i == 14) || (i == 29));
            end
        end
        foreach (obs_log[i]) begin
            vectors++;
            if (obs_log[i] !== exp_log[i]) begin
                miscompares++;
                $display("FAIL timeout cycle %0d: outputs %h, model %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_lp_relock();
        logic [7:0] g;
        clear_logs();
        restart();
        random_payload(6);
        build_stream(2);
        play(1'b0, 5);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        vectors++;
        if (lane.BYTE_VALID !== 1'b0 || lane.LOCKED !== 1'b0) begin
            miscompares++;
            $display("FAIL lp_exit: byte_valid %b locked %b, required 0 0", lane.BYTE_VALID, lane.LOCKED);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        got_q.delete();
        nfound = 0;
        random_payload(5);
        build_stream(7);
        play(1'b1, 100);
        foreach (obs_log[i]) begin
            vectors++;
            if (obs_log[i] !== exp_log[i]) begin
                miscompares++;
                $display("FAIL lp_relock cycle %0d: outputs %h, model %h", i, obs_log[i], exp_log[i]);
            end
        end
        foreach (pay_q[j]) begin
            g = (j < got_q.size()) ? got_q[j] : 8'hxx;
            vectors++;
            if (g !== pay_q[j]) begin
                miscompares++;
                $display("FAIL lp_relock byte %0d: got %h, required %h", j, g, pay_q[j]);
            end
        end
        vectors++;
        if (lane.BYTE_OFFSET !== 3'd7 || nfound != 1) begin
            miscompares++;
            $display("FAIL lp_relock_offset: offset %0d found %0d, required 7 1", lane.BYTE_OFFSET, nfound);
        end
    endtask

    task automatic test_done_drop_reset();
        clear_logs();
        restart();
        random_payload(6);
        build_stream(4);
        play(1'b0, 5);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        vectors++;
        if (lane.BYTE_VALID !== 1'b0 || lane.LOCKED !== 1'b0) begin
            miscompares++;
            $display("FAIL done_drop: byte_valid %b locked %b, required 0 0", lane.BYTE_VALID, lane.LOCKED);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        random_payload(6);
        build_stream(1);
        play(1'b0, 5);
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_mid: outputs %h, required %h", obs, 15'h0);
        end
        step(1'b1, 1'b0, 1'b1, strm_q[sidx]);
        step(1'b1, 1'b0, 1'b1, 8'h5A);
        rst = 1'b0;
        vectors++;
        if (obs !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_mid_hold: outputs %h, required %h", obs, 15'h0);
        end
        foreach (obs_log[i]) begin
            vectors++;
            if (obs_log[i] !== exp_log[i]) begin
                miscompares++;
                $display("FAIL done_reset cycle %0d: outputs %h, model %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g;
        int         k;
        for (int r = 0; r < 8; r++) begin
            clear_logs();
            restart();
            k = $urandom_range(0, 7);
            random_payload($urandom_range(3, 8));
            build_stream(k);
            play(1'b1, 100);
            foreach (obs_log[i]) begin
                vectors++;
                if (obs_log[i] !== exp_log[i]) begin
                    miscompares++;
                    $display("FAIL b2b round %0d cycle %0d: outputs %h, model %h", r, i, obs_log[i], exp_log[i]);
                end
            end
            foreach (pay_q[j]) begin
                g = (j < got_q.size()) ? got_q[j] : 8'hxx;
                vectors++;
                if (g !== pay_q[j]) begin
                    miscompares++;
                    $display("FAIL b2b round %0d byte %0d: got %h, required %h", r, j, g, pay_q[j]);
                end
            end
            vectors++;
            if (lane.BYTE_OFFSET !== 3'(k)) begin
                miscompares++;
                $display("FAIL b2b round %0d offset: %0d, required %0d", r, lane.BYTE_OFFSET, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_offset0();
        test_offset3();
        test_payload_b8();
        test_timeout();
        test_lp_relock();
        test_done_drop_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
